// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART constants and types: launch FSM encoding, lost-start timeout,
// and the baud-rate constants used by the transmitter side.
package uart_tx_fifo_pkg;

  localparam int CLK_FREQ_HZ = 50_000_000;
  localparam int BAUD_RATE   = 115_200;
  localparam int BAUD_DIV    = CLK_FREQ_HZ / BAUD_RATE;

  // Cycles WAIT_BUSY tolerates with TxD_busy low before assuming the start was missed
  localparam int WAIT_BUSY_TIMEOUT = 4;
  localparam int WAIT_CNT_W        = $clog2(WAIT_BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host push side and transmitter launch side of uart_tx_fifo in one bundle.
// slave = the buffer itself, master = the surrounding host/transmitter.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  import uart_tx_fifo_pkg::*;

  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              TxD_start;
  logic [7:0]        TxD_data;
  logic              TxD_busy;

  modport master (
    output wr_en, wr_data, TxD_busy,
    input  full, empty, count, overflow, TxD_start, TxD_data
  );

  modport slave (
    input  wr_en, wr_data, TxD_busy,
    output full, empty, count, overflow, TxD_start, TxD_data
  );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo8.sv
// Byte FIFO: DEPTH x 8 register array with wrapping pointers and registered
// full/empty/count flags. No read-through: a push into an empty FIFO is poppable next cycle.
module sync_fifo8
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] count
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   w_count_next;
  logic              r_full;
  logic              r_empty;
  logic              w_push_ok;
  logic              w_pop_ok;

  // Qualify against the pre-edge flags, so a pop never frees room for a same-edge push
  assign w_push_ok = push && !r_full;
  assign w_pop_ok  = pop && !r_empty;

  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_next = r_count + (ADDR_W + 1)'(1);
    end else if (w_pop_ok && !w_push_ok) begin
      w_count_next = r_count - (ADDR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == FULL_COUNT);
      r_empty <= (w_count_next == '0);
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = r_empty;
  assign count = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// TX byte buffer: queues host bytes and launches them one at a time into the
// RS-232 transmitter, waiting for its busy flag to cycle between bytes.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic           clk,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);

  logic                  w_pop;
  logic [7:0]            w_dout;
  logic                  w_full;
  logic                  w_empty;
  logic [ADDR_W:0]       w_count;

  tx_state_t             r_state;
  logic                  r_start;
  logic [7:0]            r_data;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic                  r_overflow;

  assign w_pop = (r_state == ST_IDLE) && !w_empty && !bus.TxD_busy;

  sync_fifo8 #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.wr_en),
    .pop   (w_pop),
    .din   (bus.wr_data),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_start    <= 1'b0;
      r_data     <= 8'h00;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_data  <= w_dout;
            r_start <= 1'b1;
            r_state <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_start    <= 1'b0;
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          // A transmitter that never raises busy must not stall the queue forever
          if (bus.TxD_busy) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_wait_cnt == WAIT_CNT_W'(WAIT_BUSY_TIMEOUT - 1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.TxD_busy) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= bus.wr_en && w_full;
    end
  end

  assign bus.TxD_start = r_start;
  assign bus.TxD_data  = r_data;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.count     = w_count;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a DEPTH=16 instance and a DEPTH=4 instance,
// each driven against a small transmitter model that raises busy after each start.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic hold_busy  = 1'b0;
  logic hold_busy4 = 1'b0;
  logic tx_mute    = 1'b0;
  logic tx_busy16, tx_busy4;
  int   tx_cnt16, tx_cnt4;

  uart_tx_fifo_if #(.ADDR_W(4)) bus16 ();
  uart_tx_fifo_if #(.ADDR_W(2)) bus4 ();

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16));
  uart_tx_fifo #(.DEPTH(4),  .ADDR_W(2)) u_dut4  (.clk(clk), .reset(reset), .bus(bus4));

  assign bus16.TxD_busy = tx_busy16 | hold_busy;
  assign bus4.TxD_busy  = tx_busy4 | hold_busy4;

  // Transmitter models: busy rises the edge after TxD_start and lasts N cycles
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_busy16 <= 1'b0; tx_cnt16 <= 0;
    end else if (tx_cnt16 != 0) begin
      tx_cnt16 <= tx_cnt16 - 1; tx_busy16 <= (tx_cnt16 > 1);
    end else if (bus16.TxD_start && !tx_mute) begin
      tx_busy16 <= 1'b1; tx_cnt16 <= 20;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_busy4 <= 1'b0; tx_cnt4 <= 0;
    end else if (tx_cnt4 != 0) begin
      tx_cnt4 <= tx_cnt4 - 1; tx_busy4 <= (tx_cnt4 > 1);
    end else if (bus4.TxD_start) begin
      tx_busy4 <= 1'b1; tx_cnt4 <= 3;
    end
  end

  // Monitors: record launched bytes and protocol statistics
  logic [7:0] out16[$];
  int         st16[$];
  int         gap16[$];
  int         cyc16 = 0, fall16 = 0, dbl16 = 0, busy_start16 = 0, unstable16 = 0, ovf16 = 0;
  logic       prev_start16 = 1'b0, prev_busy16 = 1'b0;
  logic [7:0] last_data16 = 8'h00;

  always @(negedge clk) begin
    cyc16++;
    if (reset) begin
      last_data16  = 8'h00;
      prev_start16 = 1'b0;
    end else begin
      if (bus16.TxD_start) begin
        if (prev_start16) dbl16++;
        else begin
          out16.push_back(bus16.TxD_data);
          st16.push_back(cyc16);
          gap16.push_back(cyc16 - fall16);
        end
        if (bus16.TxD_busy) busy_start16++;
        last_data16 = bus16.TxD_data;
      end else if (bus16.TxD_data !== last_data16) begin
        unstable16++;
      end
      if (bus16.overflow) ovf16++;
      if (prev_busy16 && !bus16.TxD_busy) fall16 = cyc16;
      prev_start16 = bus16.TxD_start;
    end
    prev_busy16 = bus16.TxD_busy;
  end

  logic [7:0] out4[$];
  int         max_count4 = 0, ovf4 = 0;
  logic       prev_start4 = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus4.TxD_start && !prev_start4) out4.push_back(bus4.TxD_data);
      if (int'(bus4.count) > max_count4) max_count4 = int'(bus4.count);
      if (bus4.overflow) ovf4++;
    end
    prev_start4 = bus4.TxD_start;
  end

  task automatic test_reset();
    reset = 1'b1;
    bus16.wr_en = 1'b0; bus16.wr_data = 8'h00;
    bus4.wr_en  = 1'b0; bus4.wr_data  = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (bus16.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", bus16.empty); end
    checks++; if (bus16.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", bus16.full); end
    checks++; if (bus16.count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus16.count); end
    checks++; if (bus16.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", bus16.overflow); end
    checks++; if (bus16.TxD_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%0b exp=0", bus16.TxD_start); end
    checks++; if (bus16.TxD_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus16.TxD_data); end
    checks++; if (bus4.empty !== 1'b1 || bus4.count !== 3'd0) begin failures++; $display("FAIL reset_dut4 empty=%0b count=%0d exp empty=1 count=0", bus4.empty, bus4.count); end
    @(posedge clk); #1; reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus16.TxD_start !== 1'b0) begin failures++; $display("FAIL reset_release_start got=%0b exp=0", bus16.TxD_start); end
  endtask

  task automatic test_single_byte();
    int base = out16.size();
    @(posedge clk); #1; bus16.wr_en = 1'b1; bus16.wr_data = 8'hA5;
    @(posedge clk); #1; bus16.wr_en = 1'b0;
    @(negedge clk);
    checks++; if (bus16.count !== 5'd1 || bus16.empty !== 1'b0) begin failures++; $display("FAIL single_after_push count=%0d empty=%0b exp count=1 empty=0", bus16.count, bus16.empty); end
    checks++; if (bus16.TxD_start !== 1'b0) begin failures++; $display("FAIL single_no_bypass start=%0b exp=0", bus16.TxD_start); end
    @(negedge clk);
    checks++; if (bus16.TxD_start !== 1'b1) begin failures++; $display("FAIL single_latency start=%0b exp=1", bus16.TxD_start); end
    checks++; if (bus16.TxD_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", bus16.TxD_data); end
    checks++; if (bus16.empty !== 1'b1 || bus16.count !== 5'd0) begin failures++; $display("FAIL single_popped empty=%0b count=%0d exp empty=1 count=0", bus16.empty, bus16.count); end
    @(negedge clk);
    checks++; if (bus16.TxD_start !== 1'b0) begin failures++; $display("FAIL single_pulse_width start=%0b exp=0", bus16.TxD_start); end
    repeat (30) @(negedge clk);
    checks++; if (out16.size() - base !== 1) begin failures++; $display("FAIL single_start_count got=%0d exp=1", out16.size() - base); end
  endtask

  task automatic test_burst();
    int base = out16.size();
    int dbl0 = dbl16, bs0 = busy_start16, un0 = unstable16;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      bus16.wr_en = 1'b1; bus16.wr_data = 8'(i + 1);
      @(posedge clk); #1;
    end
    bus16.wr_en = 1'b0;
    for (int k = 0; k < 400 && (out16.size() - base < 5 || !bus16.empty); k++) @(negedge clk);
    repeat (30) @(negedge clk);
    checks++; if (out16.size() - base !== 5) begin failures++; $display("FAIL burst_count got=%0d exp=5", out16.size() - base); end
    for (int j = 0; j < 5 && base + j < out16.size(); j++) begin
      checks++; if (out16[base + j] !== 8'(j + 1)) begin failures++; $display("FAIL burst_byte%0d got=%h exp=%h", j, out16[base + j], 8'(j + 1)); end
    end
    for (int j = 1; j < 5 && base + j < gap16.size(); j++) begin
      checks++; if (gap16[base + j] < 2) begin failures++; $display("FAIL burst_spacing%0d got=%0d exp>=2", j, gap16[base + j]); end
    end
    checks++; if (dbl16 - dbl0 !== 0 || busy_start16 - bs0 !== 0) begin failures++; $display("FAIL burst_protocol long_pulses=%0d start_while_busy=%0d exp 0 0", dbl16 - dbl0, busy_start16 - bs0); end
    checks++; if (unstable16 - un0 !== 0) begin failures++; $display("FAIL burst_data_stable changes=%0d exp=0", unstable16 - un0); end
  endtask

  task automatic test_lost_start();
    int base = st16.size();
    @(posedge clk); #1; tx_mute = 1'b1; bus16.wr_en = 1'b1; bus16.wr_data = 8'h80;
    @(posedge clk); #1; bus16.wr_data = 8'h81;
    @(posedge clk); #1; bus16.wr_en = 1'b0;
    for (int k = 0; k < 40 && st16.size() - base < 2; k++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++; if (st16.size() - base !== 2) begin failures++; $display("FAIL lost_start_count got=%0d exp=2", st16.size() - base); end
    if (st16.size() - base >= 2) begin
      checks++; if (st16[base + 1] - st16[base] !== 6) begin failures++; $display("FAIL lost_start_timeout got=%0d exp=6", st16[base + 1] - st16[base]); end
      checks++; if (out16[base + 1] !== 8'h81) begin failures++; $display("FAIL lost_start_byte got=%h exp=81", out16[base + 1]); end
    end
    tx_mute = 1'b0;
  endtask

  task automatic test_overflow();
    int base = out16.size();
    int ovf0 = ovf16;
    @(posedge clk); #1; hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus16.wr_en = 1'b1; bus16.wr_data = 8'(8'h20 + i);
      @(posedge clk); #1;
      if (i == 14) begin
        checks++; if (bus16.full !== 1'b0 || bus16.count !== 5'd15) begin failures++; $display("FAIL ovf_at15 full=%0b count=%0d exp full=0 count=15", bus16.full, bus16.count); end
      end
      if (i == 15) begin
        checks++; if (bus16.full !== 1'b1 || bus16.count !== 5'd16) begin failures++; $display("FAIL ovf_at16 full=%0b count=%0d exp full=1 count=16", bus16.full, bus16.count); end
        checks++; if (bus16.overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%0b exp=0", bus16.overflow); end
      end
    end
    bus16.wr_en = 1'b0;
    checks++; if (bus16.overflow !== 1'b1 || bus16.count !== 5'd16) begin failures++; $display("FAIL ovf_drop overflow=%0b count=%0d exp overflow=1 count=16", bus16.overflow, bus16.count); end
    @(posedge clk); #1;
    checks++; if (bus16.overflow !== 1'b0) begin failures++; $display("FAIL ovf_pulse got=%0b exp=0", bus16.overflow); end
    hold_busy = 1'b0;
    for (int k = 0; k < 700 && (out16.size() - base < 16 || !bus16.empty); k++) @(negedge clk);
    repeat (40) @(negedge clk);
    checks++; if (ovf16 - ovf0 !== 1) begin failures++; $display("FAIL ovf_pulse_count got=%0d exp=1", ovf16 - ovf0); end
    checks++; if (out16.size() - base !== 16) begin failures++; $display("FAIL ovf_drain_count got=%0d exp=16", out16.size() - base); end
    for (int j = 0; j < 16 && base + j < out16.size(); j++) begin
      checks++; if (out16[base + j] !== 8'(8'h20 + j)) begin failures++; $display("FAIL ovf_byte%0d got=%h exp=%h", j, out16[base + j], 8'(8'h20 + j)); end
    end
  endtask

  task automatic test_simultaneous();
    int base = out16.size();
    int base2;
    @(posedge clk); #1; hold_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus16.wr_en = 1'b1; bus16.wr_data = 8'(8'h30 + i);
      @(posedge clk); #1;
    end
    bus16.wr_data = 8'h33; hold_busy = 1'b0;
    @(posedge clk); #1; bus16.wr_en = 1'b0;
    checks++; if (bus16.count !== 5'd3) begin failures++; $display("FAIL simul_count3 got=%0d exp=3", bus16.count); end
    checks++; if (bus16.TxD_start !== 1'b1 || bus16.TxD_data !== 8'h30) begin failures++; $display("FAIL simul_pop start=%0b data=%h exp start=1 data=30", bus16.TxD_start, bus16.TxD_data); end
    for (int k = 0; k < 300 && (out16.size() - base < 4 || !bus16.empty); k++) @(negedge clk);
    repeat (30) @(negedge clk);
    checks++; if (out16.size() - base !== 4) begin failures++; $display("FAIL simul_drain3 got=%0d exp=4", out16.size() - base); end
    else begin
      checks++; if (out16[base + 3] !== 8'h33) begin failures++; $display("FAIL simul_last3 got=%h exp=33", out16[base + 3]); end
    end

    base2 = out16.size();
    @(posedge clk); #1; hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus16.wr_en = 1'b1; bus16.wr_data = 8'(8'h40 + i);
      @(posedge clk); #1;
    end
    bus16.wr_data = 8'h50; hold_busy = 1'b0;
    @(posedge clk); #1; bus16.wr_en = 1'b0;
    checks++; if (bus16.count !== 5'd15 || bus16.full !== 1'b0) begin failures++; $display("FAIL simul_full_count count=%0d full=%0b exp count=15 full=0", bus16.count, bus16.full); end
    checks++; if (bus16.overflow !== 1'b1) begin failures++; $display("FAIL simul_full_overflow got=%0b exp=1", bus16.overflow); end
    checks++; if (bus16.TxD_start !== 1'b1 || bus16.TxD_data !== 8'h40) begin failures++; $display("FAIL simul_full_pop start=%0b data=%h exp start=1 data=40", bus16.TxD_start, bus16.TxD_data); end
    for (int k = 0; k < 700 && (out16.size() - base2 < 16 || !bus16.empty); k++) @(negedge clk);
    repeat (40) @(negedge clk);
    checks++; if (out16.size() - base2 !== 16) begin failures++; $display("FAIL simul_full_drain got=%0d exp=16", out16.size() - base2); end
    else begin
      checks++; if (out16[base2 + 15] !== 8'h4F) begin failures++; $display("FAIL simul_full_last got=%h exp=4f", out16[base2 + 15]); end
    end
  endtask

  task automatic test_wrap();
    int base = out4.size();
    int ovf0 = ovf4;
    int idx  = 0;
    @(posedge clk); #1; hold_busy4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus4.wr_en = 1'b1; bus4.wr_data = 8'(8'h10 + idx); idx++;
      @(posedge clk); #1;
    end
    bus4.wr_en = 1'b0;
    checks++; if (bus4.full !== 1'b1 || bus4.count !== 3'd4) begin failures++; $display("FAIL wrap_full full=%0b count=%0d exp full=1 count=4", bus4.full, bus4.count); end
    hold_busy4 = 1'b0;
    for (int k = 0; k < 300 && idx < 10; k++) begin
      @(posedge clk); #1;
      if (!bus4.full) begin
        bus4.wr_en = 1'b1; bus4.wr_data = 8'(8'h10 + idx); idx++;
      end else begin
        bus4.wr_en = 1'b0;
      end
    end
    @(posedge clk); #1; bus4.wr_en = 1'b0;
    for (int k = 0; k < 300 && (out4.size() - base < 10 || !bus4.empty); k++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++; if (out4.size() - base !== 10) begin failures++; $display("FAIL wrap_count got=%0d exp=10", out4.size() - base); end
    for (int j = 0; j < 10 && base + j < out4.size(); j++) begin
      checks++; if (out4[base + j] !== 8'(8'h10 + j)) begin failures++; $display("FAIL wrap_byte%0d got=%h exp=%h", j, out4[base + j], 8'(8'h10 + j)); end
    end
    checks++; if (max_count4 !== 4) begin failures++; $display("FAIL wrap_max_count got=%0d exp=4", max_count4); end
    checks++; if (ovf4 - ovf0 !== 0) begin failures++; $display("FAIL wrap_overflow got=%0d exp=0", ovf4 - ovf0); end
  endtask

  task automatic test_reset_mid();
    int base;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      bus16.wr_en = 1'b1; bus16.wr_data = 8'(8'h60 + i);
      @(posedge clk); #1;
    end
    bus16.wr_en = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (bus16.count !== 5'd4 || bus16.TxD_busy !== 1'b1) begin failures++; $display("FAIL rstmid_pre count=%0d busy=%0b exp count=4 busy=1", bus16.count, bus16.TxD_busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus16.count !== 5'd0 || bus16.empty !== 1'b1) begin failures++; $display("FAIL rstmid_flush count=%0d empty=%0b exp count=0 empty=1", bus16.count, bus16.empty); end
    checks++; if (bus16.TxD_start !== 1'b0) begin failures++; $display("FAIL rstmid_start got=%0b exp=0", bus16.TxD_start); end
    repeat (2) @(posedge clk); #1; reset = 1'b0;
    base = out16.size();
    repeat (50) @(negedge clk);
    checks++; if (out16.size() - base !== 0) begin failures++; $display("FAIL rstmid_quiet starts=%0d exp=0", out16.size() - base); end

    @(posedge clk); #1; bus16.wr_en = 1'b1; bus16.wr_data = 8'h70;
    @(posedge clk); #1; bus16.wr_en = 1'b0;
    for (int k = 0; k < 10 && bus16.TxD_start !== 1'b1; k++) @(negedge clk);
    checks++; if (bus16.TxD_start !== 1'b1) begin failures++; $display("FAIL rstasync_launch got=%0b exp=1", bus16.TxD_start); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus16.TxD_start !== 1'b0 || bus16.TxD_data !== 8'h00) begin failures++; $display("FAIL rstasync_drop start=%0b data=%h exp start=0 data=00", bus16.TxD_start, bus16.TxD_data); end
    repeat (2) @(posedge clk); #1; reset = 1'b0;
    base = out16.size();
    repeat (20) @(negedge clk);
    checks++; if (out16.size() - base !== 0) begin failures++; $display("FAIL rstasync_quiet starts=%0d exp=0", out16.size() - base); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_lost_start();
    test_overflow();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim_time=%0t limit=500000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
